// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write-bus arbiter: HD44780 command
// bytes, bus-cycle state encoding and default 50 MHz cycle counts.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME       = 8'h02;
    localparam logic [7:0] LCD_CMD_ENTRY      = 8'h06;
    localparam logic [7:0] LCD_CMD_FUNC_2LINE = 8'h38;
    localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;
    localparam logic [7:0] LCD_CMD_SHIFT_R    = 8'h14;

    localparam int LCD_CNT_W          = 17;
    localparam int LCD_SETUP_CYC      = 2;
    localparam int LCD_EN_CYC         = 25;
    localparam int LCD_HOLD_CYC       = 2;
    localparam int LCD_SHORT_WAIT_CYC = 2500;
    localparam int LCD_LONG_WAIT_CYC  = 82000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_bus_state_e;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational requester picker. With LCD_RR_ARB_EN defined the search starts
// at ptr_i (round-robin); without it the lowest requesting index wins.
module lcd_rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
`ifdef LCD_RR_ARB_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
`ifdef LCD_RR_ARB_EN
    logic [IDX_W-1:0] cand;

    always_comb begin
        found   = 1'b0;
        cand    = '0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end
`else
    always_comb begin
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 write bus between N_REQ requesters and runs the full bus
// cycle (setup, EN pulse, hold, execution wait). LCD_RR_ARB_EN selects round-robin.
//
// state    | meaning
// IDLE     | bus free; grant on any req unless ack is being issued this cycle
// SETUP    | RS/data driven, EN low, SETUP_CYC cycles
// PULSE    | EN high, EN_CYC cycles
// HOLD     | EN low, RS/data held, HOLD_CYC cycles
// WAIT     | LCD execution time (short or long), then ack the winner
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int SETUP_CYC      = LCD_SETUP_CYC,
    parameter int EN_CYC         = LCD_EN_CYC,
    parameter int HOLD_CYC       = LCD_HOLD_CYC,
    parameter int SHORT_WAIT_CYC = LCD_SHORT_WAIT_CYC,
    parameter int LONG_WAIT_CYC  = LCD_LONG_WAIT_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_rs,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic                 EN_out,
    output logic                 RS_out,
    output logic                 RW_out,
    output logic [7:0]           out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [LCD_CNT_W-1:0] SETUP_M1 = LCD_CNT_W'(SETUP_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] EN_M1    = LCD_CNT_W'(EN_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] HOLD_M1  = LCD_CNT_W'(HOLD_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] SHORT_M1 = LCD_CNT_W'(SHORT_WAIT_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] LONG_M1  = LCD_CNT_W'(LONG_WAIT_CYC - 1);

    lcd_bus_state_e         state_q, state_d;
    logic [LCD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   rs_q, rs_d;
    logic [7:0]             data_q, data_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic [IDX_W-1:0]       win_q, win_d;

    logic [N_REQ-1:0]       pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_rs;
    logic [7:0]             pick_data;
    logic                   grant_fire;

`ifdef LCD_RR_ARB_EN
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_fire)
            ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
`endif

    lcd_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i   (req),
`ifdef LCD_RR_ARB_EN
        .ptr_i   (ptr_q),
`endif
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    always_comb begin
        pick_rs   = |(req_rs & pick_grant);
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) pick_data = req_data[8*i +: 8];
        end
    end

    // Holding off the grant while ack is high lets the served requester drop req.
    assign grant_fire = (state_q == ST_IDLE) && (ack_q == '0) && (|req);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        win_d   = win_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
                    rs_d    = pick_rs;
                    data_d  = pick_data;
                    win_d   = pick_idx;
                    cnt_d   = SETUP_M1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = EN_M1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_M1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = lcd_is_long_cmd(rs_q, data_q) ? LONG_M1 : SHORT_M1;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    ack_d[win_q] = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            ack_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            win_q   <= win_d;
        end
    end

    assign ack    = ack_q;
    assign busy   = (state_q != ST_IDLE);
    assign EN_out = (state_q == ST_PULSE);
    assign RS_out = rs_q;
    assign RW_out = 1'b0;
    assign out    = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: a cycle-timeline model of each granted
// write is compared against the DUT every cycle, plus literal spot checks.
module tb_lcd_bus_arbiter;

    localparam int NR = 2;
    localparam int S  = 2;
    localparam int E  = 25;
    localparam int H  = 2;
    localparam int SW = 2500;
    localparam int LW = 8000;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, req_rs;
    logic [15:0]   req_data;
    logic [1:0]    ack;
    logic          busy, EN_out, RS_out, RW_out;
    logic [7:0]    out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    lcd_bus_arbiter #(
        .N_REQ          (NR),
        .SETUP_CYC      (S),
        .EN_CYC         (E),
        .HOLD_CYC       (H),
        .SHORT_WAIT_CYC (SW),
        .LONG_WAIT_CYC  (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_rs   (req_rs),
        .req_data (req_data),
        .ack      (ack),
        .busy     (busy),
        .EN_out   (EN_out),
        .RS_out   (RS_out),
        .RW_out   (RW_out),
        .out      (out)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Arbitration rule as a plain search over requester indices.
    function automatic int pick(input logic [1:0] r, input int p);
`ifdef LCD_RR_ARB_EN
        for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
`else
        for (int k = 0; k < NR; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    // Model: a write granted in cycle g occupies cycles g+1..g+T (T = S+E+H+wait),
    // EN is high in g+S+1..g+S+E, ack is high in g+T+1; next grant from g+T+2.
    int          m_active = 0;
    int          m_g = 0, m_T = 0, m_win = 0, m_ptr = 0;
    logic        m_rs = 1'b0;
    logic [7:0]  m_data = 8'h00;

    always @(negedge clk) begin
        int          k, w;
        logic        eb, een;
        logic [1:0]  eack;
        logic [13:0] ev, av;
        k    = cyc - m_g;
        eb   = (m_active != 0) && k >= 1 && k <= m_T;
        een  = (m_active != 0) && k >= S + 1 && k <= S + E;
        eack = ((m_active != 0) && k == m_T + 1) ? 2'(1 << m_win) : 2'b00;
        ev   = {eb, een, m_rs, 1'b0, m_data, eack};
        av   = {busy, EN_out, RS_out, RW_out, out, ack};
        if (cyc >= 1) chk($sformatf("cycle_model@%0d", cyc), {18'd0, av}, {18'd0, ev});
        if (rst) begin
            m_active = 0;
            m_rs     = 1'b0;
            m_data   = 8'h00;
            m_ptr    = 0;
        end else if ((m_active == 0 || k >= m_T + 2) && req != 2'b00) begin
            w        = pick(req, m_ptr);
            m_g      = cyc;
            m_win    = w;
            m_rs     = req_rs[w];
            m_data   = req_data[8*w +: 8];
            m_T      = S + E + H +
                       ((!m_rs && m_data inside {8'h01, 8'h02, 8'h03}) ? LW : SW);
            m_ptr    = (w + 1) % NR;
            m_active = 1;
        end
    end

    // Observation log used by the literal checks.
    logic       busy_prev = 1'b0;
    int         last_start_cyc = 0, last_ack_cyc = 0, en_cnt = 0;
    logic       start_rs = 1'b0;
    logic [7:0] start_out = 8'h00;

    always @(negedge clk) begin
        if (busy === 1'b1 && busy_prev !== 1'b1) begin
            last_start_cyc = cyc;
            start_rs       = RS_out;
            start_out      = out;
            en_cnt         = 0;
        end
        if (EN_out === 1'b1) en_cnt++;
        if (ack !== 2'b00) last_ack_cyc = cyc;
        busy_prev = busy;
    end

    task automatic wait_any_ack(input int budget, output int idx);
        idx = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                idx = (ack[1] === 1'b1) ? 1 : 0;
                break;
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack within %0d cycles, required an ack", budget);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_en(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (EN_out === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL en_timeout: EN_out stayed low for %0d cycles, required high", budget);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int idx, a1;
        int order [4];
        int exp_order [4];
        rst = 1'b1; req = 2'b00; req_rs = 2'b00; req_data = 16'h0000;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {19'd0, busy, EN_out, RS_out, RW_out, out, ack}, 32'd0);
        tick(1);

        // Single data write from requester 0.
        req_rs[0] = 1'b1; req_data[7:0] = 8'h41; req[0] = 1'b1;
        wait_any_ack(10000, idx);
        req[0] = 1'b0;
        chk("data_ack_idx", idx, 0);
        chk("data_latency", last_ack_cyc - last_start_cyc, 2529);
        chk("data_en_len", en_cnt, 25);
        chk("data_rs_at_setup", start_rs, 1);
        chk("data_out_at_setup", start_out, 8'h41);
        tick(2);

        // Clear command: long wait; then function-set: short wait.
        req_rs[1] = 1'b0; req_data[15:8] = 8'h01; req[1] = 1'b1;
        wait_any_ack(20000, idx);
        req[1] = 1'b0;
        chk("clear_ack_idx", idx, 1);
        chk("clear_latency", last_ack_cyc - last_start_cyc, 8029);
        chk("model_clear_T", m_T, 8029);
        tick(2);
        req_data[15:8] = 8'h38; req[1] = 1'b1;
        wait_any_ack(10000, idx);
        req[1] = 1'b0;
        chk("func_latency", last_ack_cyc - last_start_cyc, 2529);
        tick(2);

        // Contention with both requests held.
        req_rs = 2'b11; req_data = 16'h5150; req = 2'b11;
        for (int i = 0; i < 4; i++) wait_any_ack(10000, order[i]);
        req = 2'b00;
`ifdef LCD_RR_ARB_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) chk($sformatf("contention_order%0d", i), order[i], exp_order[i]);
        tick(2);

        // Data changed mid-PULSE must not reach the bus.
        req_rs[1] = 1'b1; req_data[15:8] = 8'h30; req[1] = 1'b1;
        wait_en(100);
        tick(5);
        req_data[15:8] = 8'h31;
        @(negedge clk);
        chk("stable_out_mid_pulse", out, 8'h30);
        wait_any_ack(10000, idx);
        req[1] = 1'b0;
        tick(3);
        @(negedge clk);
        chk("stable_out_after_ack", out, 8'h30);
        tick(1);
        req[1] = 1'b1;
        wait_any_ack(10000, idx);
        req[1] = 1'b0;
        chk("next_grant_out", start_out, 8'h31);
        tick(2);

        // Reset during PULSE, request held across it.
        req_rs[0] = 1'b1; req_data[7:0] = 8'h42; req[0] = 1'b1;
        wait_en(100);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pulse_outputs", {29'd0, busy, EN_out, ack != 2'b00}, 32'd0);
        wait_any_ack(10000, idx);
        req[0] = 1'b0;
        chk("rst_regrant_idx", idx, 0);
        chk("rst_regrant_latency", last_ack_cyc - last_start_cyc, 2529);
        tick(2);

        // Back-to-back writes with req held through ack.
        req_rs[0] = 1'b1; req_data[7:0] = 8'h61; req[0] = 1'b1;
        wait_any_ack(10000, idx);
        a1 = last_ack_cyc;
        wait_any_ack(10000, idx);
        req[0] = 1'b0;
        chk("b2b_gap", last_start_cyc - a1, 2);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
